sqrt_pre_norm: RTL and testbench
================================

Name: sqrt_pre_norm

Overview:
- Upstream stage of the u32 square-root datapath; it feeds the vector-mode CORDIC array.
- Accepts a 32-bit unsigned operand over a valid/ready handshake.
- Normalizes the operand by an even left shift, then forms CORDIC inputs x = m + 0.25 and y = m - 0.25.
- Emits half the shift count (plus a zero flag and a tag) so the downstream stage can denormalize the root.

Parameters:
TAG_W, 4, width of the opaque tag carried alongside each operand (must be >= 1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  operand valid
in_ready  output  1  stage can accept operand this cycle
in_data  input  32  unsigned radicand
in_tag  input  TAG_W  opaque tag
out_valid  output  1  ix/iy/half_shift/is_zero/out_tag valid
out_ready  input  1  downstream accepts this cycle
ix  output  33  CORDIC x input, unsigned, scale 2^32
iy  output  33  CORDIC y input, unsigned, scale 2^32
half_shift  output  4  normalization shift / 2 (0..15); root must be shifted right by this
is_zero  output  1  operand was 0
out_tag  output  TAG_W  tag of this result

Behaviour:
- Reset (async, active-high) clears both stage valids; every output register is 0 (out_valid=0, ix=0, iy=0, half_shift=0, is_zero=0, out_tag=0). Asserting rst mid-operation discards all in-flight operands; no partial result survives.
- Two-stage pipeline: S1 (normalize), then S2 (x/y form). Latency is 2 cycles from an accepted input to out_valid. Throughput is 1 per cycle when out_ready=1.
- Handshake: transfer occurs when valid && ready. Each stage register loads when it is empty or its content is being consumed this cycle.
  - s2_en = !s2_valid || out_ready
  - s1_en = !s1_valid || s2_en
  - in_ready = s1_en
- in_ready depends combinationally on out_ready; there is no combinational in_valid-to-out_valid path.
- out_valid and the data outputs are held stable while out_valid && !out_ready.
- Bubbles collapse: an empty stage accepts new data even while downstream stalls.
- S1 arithmetic:
  - nz = leading-zero count of in_data (0..31; don't-care when in_data=0)
  - s = nz with bit0 cleared
  - m = in_data << s (32-bit); the top two bits of m are never 00 for nonzero input, so m/2^32 lies in [0.25, 1)
  - register m, s/2, is_zero = (in_data==0), and the tag
- S2 arithmetic, with Q = 33'h0_4000_0000 (0.25):
  - ix = {1'b0,m} + Q
  - iy = {1'b0,m} - Q
  - iy is always >= 0 and ix never overflows 33 bits
- If is_zero: ix=0, iy=0, half_shift=0, is_zero=1.
- Simultaneous push and pop while full is allowed; ordering is strictly FIFO.

Decomposition:
- Shared package sqrt_pkg holds:
  - DATA_W=32, XY_W=33
  - QUARTER = 33'h0_4000_0000
  - HS_W=4
- Sub-module lzc32: combinational leading-zero counter; 32-bit input, 5-bit count, plus an all-zero flag. It is instantiated in S1.

Test Plan:
- in_data=1, out_ready=1 -> 2 cycles later ix=0x0_8000_0000, iy=0x0_0000_0000, half_shift=15, is_zero=0.
- in_data=2 -> ix=0x0_C000_0000, iy=0x0_4000_0000, half_shift=15; in_data=4 -> m=0x4000_0000, half_shift=14.
- in_data=0xFFFF_FFFF -> ix=0x1_3FFF_FFFF, iy=0x0_BFFF_FFFF, half_shift=0.
- in_data=0, tag=5 -> ix=0, iy=0, half_shift=0, is_zero=1, out_tag=5.
- Back-to-back tags 1,2,3 with out_ready low 5 cycles -> in_ready drops after 2 accepted; outputs held stable; on release, tags 1,2,3 emerge in order with no loss or duplication.
- rst pulsed while 2 operands are in flight -> out_valid=0 and all outputs 0 immediately; first post-reset operand emerges 2 cycles after acceptance.

Source files
------------

// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared widths and constants for the u32 square-root datapath
package sqrt_pkg;
  localparam int DATA_W = 32;
  localparam int XY_W = 33;
  localparam int HS_W = 4;
  localparam logic [XY_W-1:0] QUARTER = 33'h0_4000_0000;
endpackage

// File: rtl/lzc32.sv
// lzc32: combinational leading-zero counter with all-zero flag
module lzc32 (
  input  logic [31:0] d,
  output logic [4:0]  cnt,
  output logic        zero
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 32; i++)
      if (d[i]) cnt = 5'(31 - i);
  end
  assign zero = ~|d;
endmodule

// File: rtl/sqrt_pre_norm.sv
// sqrt_pre_norm: even-shift normalization and CORDIC x/y formation, two-stage pipeline
module sqrt_pre_norm
  import sqrt_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XY_W-1:0]   ix,
  output logic [XY_W-1:0]   iy,
  output logic [HS_W-1:0]   half_shift,
  output logic              is_zero,
  output logic [TAG_W-1:0]  out_tag
);
  logic              s1_valid, s1_zero, s1_en, s2_en, all_zero;
  logic [DATA_W-1:0] s1_m;
  logic [HS_W-1:0]   s1_hs;
  logic [TAG_W-1:0]  s1_tag;
  logic [4:0]        nz;
  lzc32 u_lzc (.d(in_data), .cnt(nz), .zero(all_zero));
  assign s2_en = !out_valid || out_ready;
  assign s1_en = !s1_valid || s2_en;
  assign in_ready = s1_en;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_m       <= '0;
      s1_hs      <= '0;
      s1_zero    <= 1'b0;
      s1_tag     <= '0;
      out_valid  <= 1'b0;
      ix         <= '0;
      iy         <= '0;
      half_shift <= '0;
      is_zero    <= 1'b0;
      out_tag    <= '0;
    end else begin
      if (s1_en) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_m    <= all_zero ? '0 : in_data << {nz[4:1], 1'b0};
          s1_hs   <= all_zero ? '0 : nz[4:1];
          s1_zero <= all_zero;
          s1_tag  <= in_tag;
        end
      end
      if (s2_en) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          ix         <= s1_zero ? '0 : {1'b0, s1_m} + QUARTER;
          iy         <= s1_zero ? '0 : {1'b0, s1_m} - QUARTER;
          half_shift <= s1_hs;
          is_zero    <= s1_zero;
          out_tag    <= s1_tag;
        end
      end
    end
  end
endmodule

// File: tb/tb_sqrt_pre_norm.sv
// tb_sqrt_pre_norm: directed and random checks against a scoreboard reference
module tb_sqrt_pre_norm;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, is_zero;
  logic [31:0] in_data = '0;
  logic [3:0]  in_tag = '0, out_tag, half_shift;
  logic [32:0] ix, iy;
  typedef struct {
    logic [32:0] ix, iy;
    logic [3:0]  hs;
    logic        z;
    logic [3:0]  tag;
  } exp_t;
  exp_t q[$];
  exp_t h;
  logic hold = 1'b0, last_ir;
  int n_vec = 0, n_err = 0;
  sqrt_pre_norm #(.TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .ix(ix), .iy(iy),
    .half_shift(half_shift), .is_zero(is_zero), .out_tag(out_tag)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [31:0] d, input logic [3:0] t);
    exp_t e;
    longint m;
    int hs;
    e.tag = t;
    e.z = (d == 0);
    e.ix = '0;
    e.iy = '0;
    e.hs = '0;
    if (d != 0) begin
      m = longint'(d);
      hs = 0;
      while (m < 64'h4000_0000) begin
        m = m * 4;
        hs++;
      end
      e.ix = 33'(m + 64'h4000_0000);
      e.iy = 33'(m - 64'h4000_0000);
      e.hs = 4'(hs);
    end
    return e;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, "_ix"}, 64'(ix), 64'(e.ix));
    chk({tag, "_iy"}, 64'(iy), 64'(e.iy));
    chk({tag, "_hs"}, 64'(half_shift), 64'(e.hs));
    chk({tag, "_zero"}, 64'(is_zero), 64'(e.z));
    chk({tag, "_tag"}, 64'(out_tag), 64'(e.tag));
  endtask
  task automatic step(input logic v, input logic [31:0] d, input logic [3:0] t, input logic r);
    exp_t e;
    in_valid = v;
    in_data = d;
    in_tag = t;
    out_ready = r;
    #1;
    if (hold) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk_out("hold", h);
    end
    if (out_valid && out_ready) begin
      n_vec++;
      assert (q.size() > 0) else begin
        n_err++;
        $error("FAIL spurious_out observed=tag %0d expected=no output", out_tag);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk_out("result", e);
      end
    end
    hold = out_valid && !out_ready;
    h = '{ix, iy, half_shift, is_zero, out_tag};
    if (v && in_ready) q.push_back(model(d, t));
    last_ir = in_ready;
    @(negedge clk);
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) step(1'b0, '0, '0, 1'b1);
    chk("drained", 64'(q.size()), 64'd0);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk_out(tag, '{33'd0, 33'd0, 4'd0, 1'b0, 4'd0});
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    step(1'b1, 32'd1, 4'd1, 1'b1);
    step(1'b1, 32'd2, 4'd2, 1'b1);
    step(1'b1, 32'd4, 4'd3, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 4'd4, 1'b1);
    step(1'b1, 32'd0, 4'd5, 1'b1);
    step(1'b1, 32'h8000_0000, 4'd6, 1'b1);
    step(1'b1, 32'h0000_0003, 4'd7, 1'b1);
    drain();
    step(1'b1, 32'h0001_0000, 4'd1, 1'b0);
    step(1'b1, 32'h0000_0100, 4'd2, 1'b0);
    step(1'b1, 32'h0000_0010, 4'd3, 1'b0);
    chk("in_ready_full", 64'(last_ir), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h0000_0010, 4'd3, 1'b0);
    step(1'b1, 32'h0000_0010, 4'd3, 1'b1);
    drain();
    step(1'b1, 32'h1234_5678, 4'd8, 1'b0);
    step(1'b1, 32'h0000_0ABC, 4'd9, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    q.delete();
    hold = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 32'h0000_0100, 4'd7, 1'b1);
    chk("lat_cycle1", 64'(out_valid), 64'd0);
    step(1'b0, '0, '0, 1'b1);
    chk("lat_cycle2", 64'(out_valid), 64'd1);
    drain();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      step($urandom_range(0, 3) != 0, d, 4'($urandom), $urandom_range(0, 3) != 0);
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
